// File: rtl/rx_top.sv
// UART receiver: 2-flop input sync, oversampled start detection, 3-point
// majority bit sampling, optional parity check and stop-bit check.
module rx_top #(
    parameter int unsigned DATA_WIDTH = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic [5:0]            PRESCALE,
    input  logic                  PAR_EN,
    input  logic                  PAR_TYP,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  DATA_VALID,
    output logic                  PAR_ERR,
    output logic                  STP_ERR,
    output logic                  BUSY
);

    localparam int unsigned CNT_W = 6;
    localparam int unsigned BIT_W = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, rx_s_q;
    logic [CNT_W-1:0]       edge_cnt_q, edge_cnt_d;
    logic [BIT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [2:0]             samp_q, samp_d;
    logic [DATA_WIDTH-1:0]  data_q, data_d;
    logic                   par_en_q, par_en_d;
    logic                   par_typ_q, par_typ_d;
    logic                   par_fail_q, par_fail_d;
    logic [DATA_WIDTH-1:0]  p_data_q, p_data_d;
    logic                   data_valid_q, data_valid_d;
    logic                   par_err_q, par_err_d;
    logic                   stp_err_q, stp_err_d;
    logic                   busy_q, busy_d;

    logic [CNT_W-1:0]       mid;
    logic                   boundary;
    logic                   maj;

    assign mid      = PRESCALE >> 1;
    assign boundary = (edge_cnt_q == PRESCALE - CNT_W'(1));
    assign maj      = (samp_q[0] & samp_q[1]) | (samp_q[0] & samp_q[2]) | (samp_q[1] & samp_q[2]);

    // State and datapath registers
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sync1_q      <= 1'b1;
            rx_s_q       <= 1'b1;
            state_q      <= S_IDLE;
            edge_cnt_q   <= '0;
            bit_cnt_q    <= '0;
            samp_q       <= '0;
            data_q       <= '0;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            par_fail_q   <= 1'b0;
            p_data_q     <= '0;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            sync1_q      <= RX_IN;
            rx_s_q       <= sync1_q;
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            samp_q       <= samp_d;
            data_q       <= data_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            par_fail_q   <= par_fail_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
            busy_q       <= busy_d;
        end
    end

    // Next state, bit timing and frame datapath
    always_comb begin
        state_d    = state_q;
        edge_cnt_d = '0;
        bit_cnt_d  = bit_cnt_q;
        samp_d     = samp_q;
        data_d     = data_q;
        par_en_d   = par_en_q;
        par_typ_d  = par_typ_q;
        par_fail_d = par_fail_q;

        if (state_q != S_IDLE) begin
            edge_cnt_d = boundary ? '0 : edge_cnt_q + CNT_W'(1);
            if (edge_cnt_q == mid - CNT_W'(1)) samp_d[0] = rx_s_q;
            if (edge_cnt_q == mid)             samp_d[1] = rx_s_q;
            if (edge_cnt_q == mid + CNT_W'(1)) samp_d[2] = rx_s_q;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) state_d = S_START;
            end
            S_START: begin
                if (boundary) begin
                    if (maj) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d    = S_DATA;
                        bit_cnt_d  = '0;
                        par_en_d   = PAR_EN;
                        par_typ_d  = PAR_TYP;
                        par_fail_d = 1'b0;
                    end
                end
            end
            S_DATA: begin
                if (boundary) begin
                    data_d = {maj, data_q[DATA_WIDTH-1:1]};
                    if (bit_cnt_q == BIT_W'(DATA_WIDTH - 1)) begin
                        bit_cnt_d = '0;
                        state_d   = par_en_q ? S_PARITY : S_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    end
                end
            end
            S_PARITY: begin
                if (boundary) begin
                    par_fail_d = maj ^ (^data_q) ^ par_typ_q;
                    state_d    = S_STOP;
                end
            end
            S_STOP: begin
                // A start edge already visible at the stop boundary is taken directly
                if (boundary) state_d = rx_s_q ? S_IDLE : S_START;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Registered result pulses and status
    always_comb begin
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;
        busy_d       = (state_q != S_IDLE);

        if (state_q == S_STOP && boundary) begin
            if (!maj) begin
                stp_err_d = 1'b1;
            end else if (par_fail_q) begin
                par_err_d = 1'b1;
            end else begin
                data_valid_d = 1'b1;
                p_data_d     = data_q;
            end
        end
    end

    assign P_DATA     = p_data_q;
    assign DATA_VALID = data_valid_q;
    assign PAR_ERR    = par_err_q;
    assign STP_ERR    = stp_err_q;
    assign BUSY       = busy_q;

endmodule
